sha_msg_feeder: RTL and testbench

Upstream source for the `sha_w` message-schedule stage in the Bitcoin miner. Takes one 80-byte block header and a nonce range, and emits SHA-256-padded 512-bit message blocks on `M`/`en`:
- first, header block 0, once per job;
- then one padded block 1 per nonce, with the nonce spliced in.

Owns the nonce iteration, range termination, abort and downstream flow control.

---
 rtl/sha_pkg.sv | 19 +
 rtl/sha_msg_feeder.sv | 82 ++++++++
 tb/tb_sha_msg_feeder.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sha_pkg.sv
// sha_pkg: shared constants, feeder state enum and block-1 padding helper for the SHA message feeder.
package sha_pkg;
    localparam int          HDR_W        = 640;
    localparam int          BLK_W        = 512;
    localparam logic [7:0]  PAD_BYTE     = 8'h80;
    localparam logic [63:0] HDR_LEN_BITS = 64'd640;

    typedef enum logic [1:0] {
        IDLE,
        SEND_HDR,
        SEND_NONCE,
        DONE
    } feeder_state_t;

    // Header tail, little-endian nonce, 0x80 terminator, zero fill, 64-bit bit length.
    function automatic logic [BLK_W-1:0] pad_block1(input logic [95:0] hdr_tail, input logic [31:0] nonce);
        return {hdr_tail, nonce[7:0], nonce[15:8], nonce[23:16], nonce[31:24], PAD_BYTE, 312'd0, HDR_LEN_BITS};
    endfunction
endpackage

// File: rtl/sha_msg_feeder.sv
// sha_msg_feeder: emits header block 0 then one padded nonce block per nonce in [nonce_start, nonce_end].
module sha_msg_feeder
    import sha_pkg::*;
#(
    parameter logic [31:0] NONCE_STEP = 32'd1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [HDR_W-1:0]   header,
    input  logic [31:0]        nonce_start,
    input  logic [31:0]        nonce_end,
    input  logic               ready,
    input  logic               stop,
    output logic [BLK_W-1:0]   M,
    output logic               en,
    output logic               blk_idx,
    output logic [31:0]        nonce_out,
    output logic               busy,
    output logic               done
);
    feeder_state_t state, next_state;
    logic [607:0] hdr_q;
    logic [31:0]  nonce, end_q;
    logic         emit, last;
    logic         unused_nonce_field;

    assign unused_nonce_field = ^header[31:0];

    // Distance compare instead of nonce+step > end so a range ending at 32'hFFFF_FFFF never wraps.
    assign last = (end_q - nonce) < NONCE_STEP;
    assign emit = (state == SEND_HDR || state == SEND_NONCE) && ready && !stop;

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (state == IDLE)
            next_state = !start ? IDLE : (nonce_start > nonce_end) ? DONE : SEND_HDR;
        else if (stop || state == DONE)
            next_state = IDLE;
        else if (ready)
            next_state = (state == SEND_HDR) ? SEND_NONCE : last ? DONE : SEND_NONCE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            M         <= '0;
            en        <= 1'b0;
            blk_idx   <= 1'b0;
            nonce_out <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            hdr_q     <= '0;
            nonce     <= '0;
            end_q     <= '0;
        end else begin
            en   <= emit;
            done <= state == DONE && !stop;
            busy <= next_state != IDLE;
            if (state == IDLE && start) begin
                hdr_q <= header[639:32];
                end_q <= nonce_end;
                nonce <= nonce_start;
            end
            if (emit) begin
                blk_idx <= state == SEND_NONCE;
                M       <= (state == SEND_HDR) ? hdr_q[607:96] : pad_block1(hdr_q[95:0], nonce);
                if (state == SEND_NONCE) begin
                    nonce_out <= nonce;
                    if (!last)
                        nonce <= nonce + NONCE_STEP;
                end
            end
        end
    end
endmodule

// File: tb/tb_sha_msg_feeder.sv
// tb_sha_msg_feeder: directed scenario tests for sha_msg_feeder with hand-computed expectations.
module tb_sha_msg_feeder;
    logic         clk = 0;
    logic         reset, start, ready, stop;
    logic [639:0] header;
    logic [31:0]  nonce_start, nonce_end;
    logic [511:0] m1, m4;
    logic         en1, en4, idx1, idx4, busy1, busy4, done1, done4;
    logic [31:0]  no1, no4;

    int tests = 0;
    int fails = 0;

    logic         en_h[64], busy_h[64];
    logic [511:0] m_h[64];
    logic         bi[8];
    logic [31:0]  bn[8];
    logic [511:0] bm[8];
    int           bc[8];
    int           n_blk, done_c;

    always #5 clk = ~clk;

    sha_msg_feeder #(.NONCE_STEP(32'd1)) dut (
        .clk(clk), .reset(reset), .start(start), .header(header),
        .nonce_start(nonce_start), .nonce_end(nonce_end), .ready(ready), .stop(stop),
        .M(m1), .en(en1), .blk_idx(idx1), .nonce_out(no1), .busy(busy1), .done(done1)
    );

    sha_msg_feeder #(.NONCE_STEP(32'd4)) dut4 (
        .clk(clk), .reset(reset), .start(start), .header(header),
        .nonce_start(nonce_start), .nonce_end(nonce_end), .ready(ready), .stop(stop),
        .M(m4), .en(en4), .blk_idx(idx4), .nonce_out(no4), .busy(busy4), .done(done4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one job: start at edge 0, ready[c]/stop before edge c, stops on done or after maxc edges.
    task automatic capture(input bit s4, input logic [63:0] rdy, input int stop_c, input bit hold, input int maxc);
        logic e, d;
        n_blk  = 0;
        done_c = -1;
        for (int c = 0; c < maxc; c++) begin
            start = (c == 0) || hold;
            ready = rdy[c];
            stop  = (c == stop_c);
            tick();
            if (hold) nonce_start = 32'd50;
            e = s4 ? en4 : en1;
            d = s4 ? done4 : done1;
            en_h[c]   = e;
            busy_h[c] = s4 ? busy4 : busy1;
            m_h[c]    = s4 ? m4 : m1;
            if (e && n_blk < 8) begin
                bi[n_blk] = s4 ? idx4 : idx1;
                bn[n_blk] = s4 ? no4 : no1;
                bm[n_blk] = m_h[c];
                bc[n_blk] = c;
            end
            if (e) n_blk++;
            if (d) begin
                done_c = c;
                break;
            end
        end
        start = 0;
        stop  = 0;
    endtask

    task automatic test_reset();
        reset = 1; start = 0; ready = 0; stop = 0;
        tick(); tick();
        tests++;
        if ({m1, en1, idx1, no1, busy1, done1} !== '0) begin
            fails++; $display("FAIL reset_outputs: got en=%b busy=%b done=%b idx=%b nonce=%0h want all zero", en1, busy1, done1, idx1, no1);
        end
        reset = 0;
        tick();
    endtask

    task automatic test_basic();
        nonce_start = 0; nonce_end = 2;
        capture(0, '1, -1, 0, 20);
        tests++;
        if (n_blk !== 4) begin fails++; $display("FAIL basic_count: got %0d want 4", n_blk); end
        tests++;
        if ({bc[0], bc[1], bc[2], bc[3]} !== {32'd1, 32'd2, 32'd3, 32'd4}) begin
            fails++; $display("FAIL basic_cycles: got %0d %0d %0d %0d want 1 2 3 4", bc[0], bc[1], bc[2], bc[3]);
        end
        tests++;
        if ({bi[0], bi[1], bi[2], bi[3]} !== 4'b0111) begin
            fails++; $display("FAIL basic_blk_idx: got %b%b%b%b want 0111", bi[0], bi[1], bi[2], bi[3]);
        end
        tests++;
        if ({bn[1], bn[2], bn[3]} !== {32'd0, 32'd1, 32'd2}) begin
            fails++; $display("FAIL basic_nonces: got %0h %0h %0h want 0 1 2", bn[1], bn[2], bn[3]);
        end
        tests++;
        if (bm[3][63:0] !== 64'h280) begin fails++; $display("FAIL basic_len: got %0h want 280", bm[3][63:0]); end
        tests++;
        if (bm[3][383:376] !== 8'h80) begin fails++; $display("FAIL basic_pad: got %0h want 80", bm[3][383:376]); end
        tests++;
        if (bm[3][375:64] !== '0) begin fails++; $display("FAIL basic_zero_fill: got %0h want 0", bm[3][375:64]); end
        tests++;
        if (done_c !== 5) begin fails++; $display("FAIL basic_done_cycle: got %0d want 5", done_c); end
        tests++;
        if (busy1 !== 1'b0) begin fails++; $display("FAIL basic_busy_at_done: got %b want 0", busy1); end
        tick();
        tests++;
        if ({done1, en1} !== 2'b00) begin fails++; $display("FAIL basic_done_pulse: got done=%b en=%b want 0 0", done1, en1); end
    endtask

    task automatic test_ready();
        nonce_start = 0; nonce_end = 2;
        capture(0, ~64'b1100, -1, 0, 20);
        tests++;
        if (n_blk !== 4) begin fails++; $display("FAIL ready_count: got %0d want 4", n_blk); end
        tests++;
        if ({en_h[2], en_h[3]} !== 2'b00) begin fails++; $display("FAIL ready_low_en: got %b%b want 00", en_h[2], en_h[3]); end
        tests++;
        if (m_h[2] !== header[639:128] || m_h[3] !== header[639:128]) begin
            fails++; $display("FAIL ready_m_hold: got %0h want %0h", m_h[3], header[639:128]);
        end
        tests++;
        if ({bc[1], bc[3]} !== {32'd4, 32'd6} || done_c !== 7) begin
            fails++; $display("FAIL ready_timing: got n0@%0d n2@%0d done@%0d want 4 6 7", bc[1], bc[3], done_c);
        end
    endtask

    task automatic test_nonce_bytes();
        logic [511:0] exp1;
        nonce_start = 32'h12345678; nonce_end = 32'h12345678;
        exp1 = {header[127:32], 32'h78563412, 8'h80, 312'd0, 64'd640};
        capture(0, '1, -1, 0, 20);
        tests++;
        if (n_blk !== 2 || done_c !== 3) begin fails++; $display("FAIL bytes_count: got %0d blocks done@%0d want 2 3", n_blk, done_c); end
        tests++;
        if (bm[0] !== header[639:128]) begin fails++; $display("FAIL bytes_block0: got %0h want %0h", bm[0], header[639:128]); end
        tests++;
        if (bm[1][415:384] !== 32'h78563412) begin fails++; $display("FAIL bytes_swap: got %0h want 78563412", bm[1][415:384]); end
        tests++;
        if (bm[1] !== exp1) begin fails++; $display("FAIL bytes_block1: got %0h want %0h", bm[1], exp1); end
        tests++;
        if (bn[1] !== 32'h12345678) begin fails++; $display("FAIL bytes_nonce_out: got %0h want 12345678", bn[1]); end
    endtask

    task automatic test_wrap();
        nonce_start = 32'hFFFF_FFFE; nonce_end = 32'hFFFF_FFFF;
        capture(0, '1, -1, 0, 20);
        tests++;
        if (n_blk !== 3 || bn[1] !== 32'hFFFF_FFFE || bn[2] !== 32'hFFFF_FFFF) begin
            fails++; $display("FAIL wrap_nonces: got %0d blocks %0h %0h want 3 fffffffe ffffffff", n_blk, bn[1], bn[2]);
        end
        tests++;
        if (done_c !== 4) begin fails++; $display("FAIL wrap_done: got %0d want 4", done_c); end
        ready = 1;
        tick(); tick();
        tests++;
        if ({en1, busy1} !== 2'b00) begin fails++; $display("FAIL wrap_after: got en=%b busy=%b want 0 0", en1, busy1); end
    endtask

    task automatic test_empty();
        nonce_start = 5; nonce_end = 3;
        capture(0, '1, -1, 0, 10);
        tests++;
        if (n_blk !== 0) begin fails++; $display("FAIL empty_count: got %0d want 0", n_blk); end
        tests++;
        if (done_c !== 1 || busy_h[0] !== 1'b1) begin fails++; $display("FAIL empty_done: got done@%0d busy0=%b want 1 1", done_c, busy_h[0]); end
    endtask

    task automatic test_stop();
        nonce_start = 0; nonce_end = 9;
        capture(0, '1, 3, 0, 12);
        tests++;
        if (n_blk !== 2) begin fails++; $display("FAIL stop_count: got %0d want 2", n_blk); end
        tests++;
        if ({en_h[3], busy_h[3]} !== 2'b00) begin fails++; $display("FAIL stop_outputs: got en=%b busy=%b want 0 0", en_h[3], busy_h[3]); end
        tests++;
        if (done_c !== -1) begin fails++; $display("FAIL stop_no_done: got done@%0d want none", done_c); end
    endtask

    task automatic test_reset_mid();
        nonce_start = 0; nonce_end = 9; ready = 1;
        start = 1; tick(); start = 0;
        tick(); tick();
        reset = 1; tick();
        tests++;
        if ({m1, en1, idx1, no1, busy1, done1} !== '0) begin
            fails++; $display("FAIL reset_mid: got en=%b busy=%b done=%b idx=%b nonce=%0h want all zero", en1, busy1, done1, idx1, no1);
        end
        reset = 0;
        tick();
    endtask

    task automatic test_back_to_back();
        nonce_start = 0; nonce_end = 2;
        capture(0, '1, -1, 1, 20);
        tests++;
        if (n_blk !== 4 || bn[1] !== 0 || bn[3] !== 2 || done_c !== 5) begin
            fails++; $display("FAIL busy_start: got %0d blocks n0=%0h n2=%0h done@%0d want 4 0 2 5", n_blk, bn[1], bn[3], done_c);
        end
        nonce_start = 7; nonce_end = 8;
        capture(0, '1, -1, 0, 20);
        tests++;
        if (n_blk !== 3 || bn[1] !== 7 || bn[2] !== 8 || done_c !== 4) begin
            fails++; $display("FAIL restart: got %0d blocks %0h %0h done@%0d want 3 7 8 4", n_blk, bn[1], bn[2], done_c);
        end
    endtask

    task automatic test_step4();
        reset = 1; tick(); reset = 0; tick();
        nonce_start = 0; nonce_end = 9;
        capture(1, '1, -1, 0, 20);
        tests++;
        if (n_blk !== 4 || {bn[1], bn[2], bn[3]} !== {32'd0, 32'd4, 32'd8}) begin
            fails++; $display("FAIL step4_nonces: got %0d blocks %0h %0h %0h want 4 0 4 8", n_blk, bn[1], bn[2], bn[3]);
        end
        tests++;
        if (done_c !== 5) begin fails++; $display("FAIL step4_done: got %0d want 5", done_c); end
    endtask

    initial begin
        for (int k = 0; k < 80; k++) header[639-8*k -: 8] = 8'(k + 1);
        header[31:0] = 32'hAAAA_AAAA;
        nonce_start = 0; nonce_end = 0;
        test_reset();
        test_basic();
        test_ready();
        test_nonce_bytes();
        test_wrap();
        test_empty();
        test_stop();
        test_reset_mid();
        test_back_to_back();
        test_step4();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
